// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Per-register countdown scoreboard that detects read-after-write hazards
// for the instruction in ID and drives PC / IF-ID hold and ID/EX bubble
// insertion. Each in-flight writer carries its own result latency, which
// lets loads, ALU ops and multi-cycle multiplies be handled uniformly. It
// also handles branch operands that are compared in ID, and data-memory
// wait states.
//
// Optional feature: define HAZ_STAT_EN to enable the saturating
// stall/bubble statistics counters. When the macro is undefined, the
// statistics ports are tied to 0 and no counter flops exist.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   id_valid_i            IF/ID holds a real instruction
//   id_rs_i, id_rt_i      source registers; id_use_rs_i/id_use_rt_i qualify them
//   id_branch_i           ID instruction compares its operands in ID
//   id_wr_i, id_rd_i      ID instruction writes register id_rd_i
//   id_lat_i              cycles until that result reaches the ID comparator
//   flush_i               ID instruction squashed this cycle
//   mem_busy_i            data memory wait state, whole pipeline frozen
//   pc_stall_o            hold PC
//   ifid_stall_o          hold IF/ID
//   idex_bubble_o         load NOP control into ID/EX
//   stall_cycles_o        hazard stall cycles (HAZ_STAT_EN)
//   bubble_cnt_o          bubbles inserted (HAZ_STAT_EN)
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 3,
    parameter int MAX_LAT  = 6,
    parameter int BR_EXTRA = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_i,
    input  logic [ADDR_W-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_branch_i,
    input  logic              id_wr_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    input  logic [CNT_W-1:0]  id_lat_i,
    input  logic              flush_i,
    input  logic              mem_busy_i,
    output logic              pc_stall_o,
    output logic              ifid_stall_o,
    output logic              idex_bubble_o,
    output logic [STAT_W-1:0] stall_cycles_o,
    output logic [STAT_W-1:0] bubble_cnt_o
);

    localparam logic [CNT_W-1:0] BR_X    = CNT_W'(BR_EXTRA);
    localparam logic [CNT_W-1:0] LAT_MAX = CNT_W'(MAX_LAT);

    // Entry 0 exists only to keep indexing simple; it is never loaded.
    logic [CNT_W-1:0] cnt [NUM_REGS];

    logic             rs_trk, rt_trk;
    logic [CNT_W-1:0] cnt_rs, cnt_rt;
    logic             haz, issue;

    // Branch compares happen in ID and need the value BR_EXTRA cycles
    // earlier than an EX consumer, which forwarding serves.
    function automatic logic src_haz(input logic [CNT_W-1:0] c,
                                     input logic trk, input logic br);
        return trk && (br ? (c != '0) : (c > BR_X));
    endfunction

    function automatic logic [CNT_W-1:0] clamp_lat(input logic [CNT_W-1:0] l);
        return (l > LAT_MAX) ? LAT_MAX : l;
    endfunction

    always_comb begin
        rs_trk = id_use_rs_i && (id_rs_i != '0) && (32'(id_rs_i) < NUM_REGS);
        rt_trk = id_use_rt_i && (id_rt_i != '0) && (32'(id_rt_i) < NUM_REGS);
        cnt_rs = '0;
        cnt_rt = '0;
        if (rs_trk) cnt_rs = cnt[id_rs_i];
        if (rt_trk) cnt_rt = cnt[id_rt_i];
        haz   = id_valid_i && !flush_i &&
                (src_haz(cnt_rs, rs_trk, id_branch_i) ||
                 src_haz(cnt_rt, rt_trk, id_branch_i));
        issue = id_valid_i && !flush_i && !haz && !mem_busy_i;
    end

    assign pc_stall_o    = haz | mem_busy_i;
    assign ifid_stall_o  = haz | mem_busy_i;
    assign idex_bubble_o = haz & ~mem_busy_i;

    // Scoreboard: a new writer's load takes priority over the countdown of
    // the same entry; a memory wait freezes everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else if (!mem_busy_i) begin
            cnt[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (issue && id_wr_i && (id_rd_i == ADDR_W'(i)))
                    cnt[i] <= clamp_lat(id_lat_i);
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

`ifdef HAZ_STAT_EN
    logic [STAT_W-1:0] stall_cnt_q, bub_cnt_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            bub_cnt_q   <= '0;
        end else begin
            if (haz && !mem_busy_i) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (idex_bubble_o)      bub_cnt_q   <= sat_inc(bub_cnt_q);
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign bubble_cnt_o   = bub_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign bubble_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 3;
    localparam int STAT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs, id_rt, id_rd;
    logic              id_use_rs, id_use_rt, id_branch, id_wr;
    logic [CNT_W-1:0]  id_lat;
    logic              flush, mem_busy;
    logic              pc_stall, ifid_stall, idex_bubble;
    logic [STAT_W-1:0] stall_cycles, bubble_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int st, bu;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_valid_i     (id_valid),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_use_rs_i    (id_use_rs),
        .id_use_rt_i    (id_use_rt),
        .id_branch_i    (id_branch),
        .id_wr_i        (id_wr),
        .id_rd_i        (id_rd),
        .id_lat_i       (id_lat),
        .flush_i        (flush),
        .mem_busy_i     (mem_busy),
        .pc_stall_o     (pc_stall),
        .ifid_stall_o   (ifid_stall),
        .idex_bubble_o  (idex_bubble),
        .stall_cycles_o (stall_cycles),
        .bubble_cnt_o   (bubble_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected statistics value: counters only exist with the feature on.
    function automatic int stat_exp(input int v);
`ifdef HAZ_STAT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic idle();
        id_valid  = 1'b0;
        id_rs     = '0;
        id_rt     = '0;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        id_branch = 1'b0;
        id_wr     = 1'b0;
        id_rd     = '0;
        id_lat    = '0;
        flush     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Producer with no sources: never stalls, issues at the next edge.
    task automatic issue_wr(input logic [ADDR_W-1:0] d, input logic [CNT_W-1:0] l);
        idle();
        id_valid = 1'b1;
        id_wr    = 1'b1;
        id_rd    = d;
        id_lat   = l;
        tick();
        idle();
    endtask

    // Present a consumer and hold it until it issues; count stall and
    // bubble cycles (bounded so a stuck stall shows up as a wrong count).
    task automatic consume(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                           input logic ua, input logic ub, input logic br,
                           input logic w, input logic [ADDR_W-1:0] d,
                           input logic [CNT_W-1:0] l,
                           output int stalls, output int bubbles);
        idle();
        id_valid  = 1'b1;
        id_rs     = a;
        id_rt     = b;
        id_use_rs = ua;
        id_use_rt = ub;
        id_branch = br;
        id_wr     = w;
        id_rd     = d;
        id_lat    = l;
        stalls    = 0;
        bubbles   = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!pc_stall) break;
            stalls++;
            if (idex_bubble) bubbles++;
            tick();
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        mem_busy = 1'b0;
        rst      = 1'b1;
        #12;
        check("rst_pc_stall", int'(pc_stall), 0);
        check("rst_ifid_stall", int'(ifid_stall), 0);
        check("rst_bubble", int'(idex_bubble), 0);
        check("rst_stall_cycles", int'(stall_cycles), 0);
        check("rst_bubble_cnt", int'(bubble_cnt), 0);
        rst = 1'b0;
        tick();

        // lw r8 ; add r9,r8,r1
        issue_wr(5'd8, 3'd2);
        consume(5'd8, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 3'd1, st, bu);
        check("loaduse_stalls", st, 1);
        check("loaduse_bubbles", bu, 1);
        check("loaduse_stat_stall", int'(stall_cycles), stat_exp(1));
        check("loaduse_stat_bubble", int'(bubble_cnt), stat_exp(1));

        // add r5 ; beq r5,r0  and  add r5 ; sub r6,r5,r2
        issue_wr(5'd5, 3'd1);
        consume(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, st, bu);
        check("alu_branch_stalls", st, 1);
        issue_wr(5'd5, 3'd1);
        consume(5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 3'd1, st, bu);
        check("alu_ex_stalls", st, 0);

        // mul r10 ; beq r10,r11 / mul r10 ; add / clamp 7 -> 6
        issue_wr(5'd10, 3'd4);
        consume(5'd10, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, st, bu);
        check("mul_branch_stalls", st, 4);
        issue_wr(5'd10, 3'd4);
        consume(5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 3'd1, st, bu);
        check("mul_ex_stalls", st, 3);
        check("mul_ex_bubbles", bu, 3);
        issue_wr(5'd12, 3'd7);
        consume(5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, st, bu);
        check("clamp_branch_stalls", st, 6);

        // r0 is never tracked
        issue_wr(5'd0, 3'd2);
        consume(5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, st, bu);
        check("r0_stalls", st, 0);

        // lw r3 ; flushed consumer ; cnt[r3] keeps counting (2 -> 1)
        issue_wr(5'd3, 3'd2);
        id_valid  = 1'b1;
        id_rs     = 5'd3;
        id_use_rs = 1'b1;
        id_branch = 1'b1;
        flush     = 1'b1;
        #1;
        check("flush_pc_stall", int'(pc_stall), 0);
        check("flush_bubble", int'(idex_bubble), 0);
        tick();
        idle();
        consume(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, st, bu);
        check("after_flush_stalls", st, 0);

        // lw r4 ; consumer held through 3 memory wait cycles
        issue_wr(5'd4, 3'd2);
        id_valid  = 1'b1;
        id_rs     = 5'd4;
        id_use_rs = 1'b1;
        mem_busy  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("busy_pc_stall", int'(pc_stall), 1);
            check("busy_ifid_stall", int'(ifid_stall), 1);
            check("busy_bubble", int'(idex_bubble), 0);
            tick();
        end
        mem_busy = 1'b0;
        consume(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, st, bu);
        check("busy_release_stalls", st, 1);
        check("busy_release_bubbles", bu, 1);

        // add r7,r7 writing r7: reads old cnt, then beq r7 sees the new one
        consume(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 3'd1, st, bu);
        check("selfdep_stalls", st, 0);
        consume(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, st, bu);
        check("selfdep_branch_stalls", st, 1);
        // 1 + 1 + 4 + 3 + 6 + 1 + 1 hazard cycles so far
        check("total_stat_stall", int'(stall_cycles), stat_exp(17));
        check("total_stat_bubble", int'(bubble_cnt), stat_exp(17));

        // Async reset in the middle of a mul stall
        issue_wr(5'd10, 3'd4);
        id_valid  = 1'b1;
        id_rs     = 5'd10;
        id_use_rs = 1'b1;
        #1;
        check("pre_rst_stall", int'(pc_stall), 1);
        tick();
        #1;
        check("pre_rst_stall2", int'(pc_stall), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_pc_stall", int'(pc_stall), 0);
        check("midrst_ifid_stall", int'(ifid_stall), 0);
        check("midrst_bubble", int'(idex_bubble), 0);
        check("midrst_stat_stall", int'(stall_cycles), 0);
        #1;
        rst = 1'b0;
        tick();
        idle();
        consume(5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, st, bu);
        check("post_rst_stalls", st, 0);
        check("post_rst_stat_stall", int'(stall_cycles), 0);
        check("post_rst_stat_bubble", int'(bubble_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage load-use hazard detector.
- Keeps a per-register countdown scoreboard of in-flight writers, each with its own result latency (ALU, load, multi-cycle multiply), instead of comparing against the single ID/EX instruction.
- Drives PC / IF-ID hold and ID/EX bubble insertion. Handles branch operands compared in ID and data-memory wait states.
- Sits between the decoder/control in ID and the pipeline registers.

Parameters:
- NUM_REGS, 32, architectural registers tracked; register 0 is never tracked.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- CNT_W, 3, scoreboard counter width.
- MAX_LAT, 6, latency clamp; must be <= 2**CNT_W-1.
- BR_EXTRA, 1, extra cycles a branch compare in ID needs relative to an EX-stage consumer.
- STAT_W, 16, statistics counter width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- id_valid_i  in  1  IF/ID holds a real (non-bubble) instruction
- id_rs_i  in  ADDR_W  source register 1 of ID instruction
- id_rt_i  in  ADDR_W  source register 2 of ID instruction
- id_use_rs_i  in  1  ID instruction reads rs
- id_use_rt_i  in  1  ID instruction reads rt
- id_branch_i  in  1  ID instruction compares operands in ID (beq/bne)
- id_wr_i  in  1  ID instruction writes a register
- id_rd_i  in  ADDR_W  destination of ID instruction
- id_lat_i  in  CNT_W  cycles until its result is visible to an ID branch compare
- flush_i  in  1  ID instruction squashed this cycle
- mem_busy_i  in  1  data memory wait state; whole pipeline frozen
- pc_stall_o  out  1  hold PC
- ifid_stall_o  out  1  hold IF/ID
- idex_bubble_o  out  1  load NOP control into ID/EX
- stall_cycles_o  out  STAT_W  hazard stall cycles (optional feature)
- bubble_cnt_o  out  STAT_W  bubbles inserted (optional feature)

Behaviour:
- State: cnt[1..NUM_REGS-1], CNT_W bits each. Value = cycles until the register's pending value reaches the ID branch comparator. 0 = ready.
- Reset (async, rst_i=1):
  - all cnt = 0.
  - statistics = 0.
  - outputs follow the combinational rules below, so with id_valid_i=0 and mem_busy_i=0 all stall/bubble outputs are 0.
- Source hazard for register r (r != 0, use bit set):
  - Branch consumer (id_branch_i=1): cnt[r] != 0.
  - Otherwise: cnt[r] > BR_EXTRA.
  - r == 0 is never a hazard.
- haz = id_valid_i & !flush_i & (rs hazard | rt hazard). Computed combinationally from registered cnt; zero-cycle latency to outputs.
- Outputs:
  - pc_stall_o = ifid_stall_o = haz | mem_busy_i.
  - idex_bubble_o = haz & !mem_busy_i.
- issue = id_valid_i & !flush_i & !haz & !mem_busy_i.
- Per clock edge, when mem_busy_i=0:
  - every nonzero cnt decrements by 1.
  - if issue & id_wr_i & id_rd_i != 0: cnt[id_rd_i] <= min(id_lat_i, MAX_LAT). The load wins over the decrement of the same entry.
- When mem_busy_i=1: all cnt frozen; no loads.
- Latency encoding used by control:
  - ALU = BR_EXTRA, so an EX consumer never stalls; forwarding covers it.
  - load = BR_EXTRA+1.
  - multiply = BR_EXTRA+3.
  - no-write instructions: id_wr_i=0.
- Self-dependence (rd == rs, not stalled): reads use the old cnt; the new cnt is installed after the edge.
- Flush with haz sources: no stall, no bubble, no scoreboard update.
- id_rs_i/id_rt_i >= NUM_REGS: treated as not tracked; no hazard.
- Reset mid-stall: counters clear immediately and stall drops combinationally.

Optional Feature:
- Macro HAZ_STAT_EN.
- Defined:
  - stall_cycles_o increments on every edge with haz=1 & mem_busy_i=0.
  - bubble_cnt_o increments on every edge with idex_bubble_o=1.
  - both saturate at all-ones and clear on reset.
- Undefined: both ports remain present, driven constant 0, and no counter flops are synthesised.

Test Plan:
- Load-use: issue lw to r8 (id_lat_i=2), next ID add r9,r8,r1 (non-branch) -> exactly 1 cycle of pc_stall_o=ifid_stall_o=idex_bubble_o=1, then add issues; bubble_cnt_o=1 if enabled.
- Branch after ALU: add r5 (id_lat_i=1), next ID beq r5,r0 -> 1 stall cycle. Same add followed by sub r6,r5,r2 -> 0 stall cycles.
- Multiply latency: mul r10 (id_lat_i=4), next ID beq r10,r11 -> 4 stall cycles. A non-branch consumer stalls 3 cycles. An id_lat_i=7 request is clamped to 6.
- Register 0 and flush: lw r0 then add using r0 -> no stall. lw r3 then a consumer of r3 with flush_i=1 -> no stall, no bubble, cnt[r3] keeps counting down.
- Memory wait: lw r4 (lat 2), consumer in ID, mem_busy_i=1 for 3 cycles -> stalls held, idex_bubble_o=0, cnt[r4] frozen. After release, 1 hazard bubble as in the load-use case.
- Reset: assert rst_i asynchronously during a 3-cycle mul stall -> stall outputs drop before the next edge. After release, all cnt=0 and statistics=0.
